// File: rtl/scan_pkg.sv
// Shared types and default widths for the frame-scan sequencer.
// The state enum is exported so the FSM state can be observed from outside.
package scan_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int CNT_W_DEF    = 10;
  localparam int ADDR_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    CALC = 3'd2,
    WAIT = 3'd3,
    REQ  = 3'd4,
    DONE = 3'd5
  } scan_state_t;

  function automatic logic state_is_busy(input scan_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Row/column raster position for the scan sequencer.
// The column always counts up; any reversal is applied by addr_calc through incdec.
module scan_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] col_cnt,
  output logic             last_col,
  output logic             last_pix
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic last_row;

  assign last_col = (col_cnt == (width - ONE));
  assign last_row = (row_cnt == (height - ONE));
  assign last_pix = last_col && last_row;

  // On the last pixel the position is held so the final coordinates stay
  // visible until the next frame clears them.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (advance && !last_pix) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + ONE;
      end else begin
        col_cnt <= col_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Frame-scan sequencer: walks the raster, drives addr_calc and issues one
// memory read per pixel. Memory handshake: a request is presented while
// mem_req is high with mem_addr stable; it completes on any rising edge where
// mem_req and mem_ack are both high; mem_req drops the cycle after.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ADDR_LAT = ADDR_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  img_width,
  input  logic [CNT_W-1:0]  img_height,
  input  logic              reverse,
  input  logic [ADDR_W-1:0] calc_addr,
  input  logic              mem_ack,
  output logic              init,
  output logic [ADDR_W-1:0] base_addr,
  output logic              addr_calc_en,
  output logic              new_row,
  output logic              incdec,
  output logic [CNT_W-1:0]  row_cnt,
  output logic [CNT_W-1:0]  col_cnt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output scan_state_t       state_dbg
);

  localparam int LAT_W = (ADDR_LAT > 1) ? $clog2(ADDR_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADDR_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] height_q;
  logic [LAT_W-1:0] wait_cnt;
  logic             cfg_ok;
  logic             start_ok;
  logic             start_bad;
  logic             wait_last;
  logic             cnt_advance;
  logic             last_col;
  logic             last_pix;

  assign cfg_ok    = (img_width != '0) && (img_height != '0);
  assign start_ok  = (state == IDLE) && start && cfg_ok;
  assign start_bad = (state == IDLE) && start && !cfg_ok;
  assign wait_last = (state == WAIT) && (wait_cnt == LAT_LAST);

  // abort outranks mem_ack, so an aborted pixel never advances the raster.
  assign cnt_advance = (state == REQ) && mem_ack && !abort;

  scan_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .advance  (cnt_advance),
    .width    (width_q),
    .height   (height_q),
    .row_cnt  (row_cnt),
    .col_cnt  (col_cnt),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = INIT;
        end
      end
      INIT: state_next = CALC;
      CALC: state_next = WAIT;
      WAIT: begin
        if (wait_last) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_next = last_pix ? DONE : CALC;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state_is_busy(state)) begin
      state_next = IDLE;
    end
  end

  // WAIT lasts ADDR_LAT cycles; the CALC cycle is the first latency cycle,
  // so calc_addr is valid on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + LAT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q   <= '0;
      height_q  <= '0;
      base_addr <= '0;
      incdec    <= 1'b0;
    end else if (start_ok) begin
      width_q   <= img_width;
      height_q  <= img_height;
      base_addr <= start_addr;
      incdec    <= reverse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (wait_last && !abort) begin
      mem_addr <= calc_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= start_bad;
    end
  end

  always_comb begin
    init         = (state == INIT);
    addr_calc_en = (state == CALC);
    new_row      = (state == CALC) && (col_cnt == '0) && (row_cnt != '0);
    mem_req      = (state == REQ);
    frame_done   = (state == DONE);
    busy         = state_is_busy(state);
    state_dbg    = state;
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: an addr_calc model feeds calc_addr, a responder
// acks requests, and a monitor checks every request against an expected queue.
module tb_scan_ctrl;
  import scan_pkg::*;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 10;

  typedef struct packed {
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } pix_t;

  // clock / reset / DUT
  logic              tb_clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  img_width = '0;
  logic [CNT_W-1:0]  img_height = '0;
  logic              reverse = 1'b0;
  logic [ADDR_W-1:0] calc_addr = '0;
  logic              mem_ack = 1'b0;
  logic              init;
  logic [ADDR_W-1:0] base_addr;
  logic              addr_calc_en;
  logic              new_row;
  logic              incdec;
  logic [CNT_W-1:0]  row_cnt;
  logic [CNT_W-1:0]  col_cnt;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              frame_done;
  logic              err;
  scan_state_t       state_dbg;

  always #5 tb_clk = ~tb_clk;

  scan_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ADDR_LAT(1)) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .start_addr   (start_addr),
    .img_width    (img_width),
    .img_height   (img_height),
    .reverse      (reverse),
    .calc_addr    (calc_addr),
    .mem_ack      (mem_ack),
    .init         (init),
    .base_addr    (base_addr),
    .addr_calc_en (addr_calc_en),
    .new_row      (new_row),
    .incdec       (incdec),
    .row_cnt      (row_cnt),
    .col_cnt      (col_cnt),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .busy         (busy),
    .frame_done   (frame_done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // scoreboard state
  pix_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cur_w = 1;
  logic        exp_incdec = 1'b0;
  logic [31:0] exp_base = '0;
  int          delay_pix = -1;
  int          delay_cycles = 0;
  int          hs_count = 0;
  int          hs_base = 0;
  int          init_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          nr_cnt = 0;
  int          nr_base = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // addr_calc model: valid one cycle after the enable pulse, junk otherwise
  always @(posedge tb_clk) begin
    if (addr_calc_en)
      calc_addr <= base_addr + 32'(row_cnt) * 32'(cur_w)
                   + (incdec ? (32'(cur_w) - 32'd1 - 32'(col_cnt)) : 32'(col_cnt));
    else
      calc_addr <= 32'hDEAD_BEEF;
  end

  // responder: ack after the configured number of waiting cycles
  initial begin : responder
    int req_age;
    int need;
    req_age = 0;
    forever begin
      @(posedge tb_clk);
      #1;
      if (mem_req === 1'b1) begin
        need    = ((hs_count - hs_base) == delay_pix) ? delay_cycles : 0;
        mem_ack = (req_age == need);
        req_age++;
      end else begin
        mem_ack = 1'b0;
        req_age = 0;
      end
    end
  end

  // monitor: pops and compares on each request cycle / handshake
  initial begin : monitor
    int   req_len;
    pix_t head;
    req_len = 0;
    forever begin
      @(negedge tb_clk);
      if (rst === 1'b0) begin
        if (init === 1'b1) init_cnt++;
        if (frame_done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (new_row === 1'b1) begin
          nr_cnt++;
          check("new_row_col", 64'(col_cnt), 64'd0);
          check("new_row_row", 64'(row_cnt), 64'(nr_cnt - nr_base));
        end
        if (busy === 1'b1) begin
          check("incdec", 64'(incdec), 64'(exp_incdec));
          check("base_addr", 64'(base_addr), 64'(exp_base));
        end
        if (mem_req === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_req: got addr %0h row %0d col %0d, required no request",
                     mem_addr, row_cnt, col_cnt);
          end else begin
            head = exp_q[0];
            req_len++;
            check("req_addr", 64'(mem_addr), 64'(head.addr));
            check("req_row", 64'(row_cnt), 64'(head.row));
            check("req_col", 64'(col_cnt), 64'(head.col));
            if (mem_ack === 1'b1) begin
              check("req_len", 64'(req_len), 64'(head.len));
              void'(exp_q.pop_front());
              hs_count++;
              req_len = 0;
            end
          end
        end else begin
          req_len = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic push_pix(input int r, input int c, input int w, input logic [31:0] base,
                          input logic rev, input int len);
    pix_t p;
    p.row  = CNT_W'(r);
    p.col  = CNT_W'(c);
    p.addr = base + 32'(r * w) + (rev ? 32'(w - 1 - c) : 32'(c));
    p.len  = 8'(len);
    exp_q.push_back(p);
  endtask

  task automatic pulse_start(input logic [31:0] base, input int w, input int h, input logic rev);
    @(negedge tb_clk);
    start_addr = base;
    img_width  = CNT_W'(w);
    img_height = CNT_W'(h);
    reverse    = rev;
    start      = 1'b1;
    @(posedge tb_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] base, input int w, input int h, input logic rev,
                           input int dpix, input int dcyc);
    int cycles;
    int limit;
    int done0;
    int init0;
    logic got;
    delay_pix    = dpix;
    delay_cycles = dcyc;
    cur_w        = w;
    exp_incdec   = rev;
    exp_base     = base;
    for (int i = 0; i < w * h; i++)
      push_pix(i / w, i % w, w, base, rev, (i == dpix) ? dcyc + 1 : 1);
    hs_base = hs_count;
    nr_base = nr_cnt;
    done0   = done_cnt;
    init0   = init_cnt;
    pulse_start(base, w, h, rev);
    cycles = 0;
    got    = 1'b0;
    limit  = 3 * w * h + dcyc + 40;
    while (!got && cycles < limit) begin
      @(negedge tb_clk);
      cycles++;
      if (frame_done === 1'b1) got = 1'b1;
    end
    check("frame_done_seen", 64'(got), 64'd1);
    check("frame_cycles", 64'(cycles), 64'(3 * w * h + 2 + dcyc));
    @(negedge tb_clk);
    check("idle_after_done", 64'(busy), 64'd0);
    check("final_row", 64'(row_cnt), 64'(h - 1));
    check("final_col", 64'(col_cnt), 64'(w - 1));
    check("done_count", 64'(done_cnt - done0), 64'd1);
    check("init_count", 64'(init_cnt - init0), 64'd1);
    check("new_row_count", 64'(nr_cnt - nr_base), 64'(h - 1));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // stimulus
  initial begin : stimulus
    int   err0;
    int   init0;
    int   done0;
    logic found;

    // 1: reset with start held high
    rst        = 1'b1;
    start      = 1'b1;
    reverse    = 1'b1;
    img_width  = CNT_W'(3);
    img_height = CNT_W'(2);
    start_addr = 32'd77;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_init", 64'(init), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_base_addr", 64'(base_addr), 64'd0);
    check("rst_incdec", 64'(incdec), 64'd0);
    check("rst_counters", 64'({row_cnt, col_cnt}), 64'd0);
    check("rst_pulses", 64'({addr_calc_en, new_row, frame_done, err}), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge tb_clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_init", 64'(init_cnt), 64'd0);

    // 2: 3x2 frame, immediate ack
    run_frame(32'd100, 3, 2, 1'b0, -1, 0);

    // 3: 4x1 reversed
    run_frame(32'd300, 4, 1, 1'b1, -1, 0);

    // 4: 3x2 with pixel 2 acked after 5 extra cycles
    run_frame(32'd2000, 3, 2, 1'b0, 2, 5);

    // 5: illegal sizes, then a 1x1 frame
    err0  = err_cnt;
    init0 = init_cnt;
    pulse_start(32'd50, 0, 5, 1'b0);
    @(negedge tb_clk);
    check("err_pulse_w0", 64'(err), 64'd1);
    check("err_busy_w0", 64'(busy), 64'd0);
    @(negedge tb_clk);
    check("err_single_cycle", 64'(err), 64'd0);
    pulse_start(32'd50, 5, 0, 1'b0);
    @(negedge tb_clk);
    check("err_pulse_h0", 64'(err), 64'd1);
    check("err_busy_h0", 64'(busy), 64'd0);
    @(negedge tb_clk);
    check("err_count", 64'(err_cnt - err0), 64'd2);
    check("err_no_init", 64'(init_cnt - init0), 64'd0);
    run_frame(32'd900, 1, 1, 1'b0, -1, 0);

    // 6: abort coinciding with ack on pixel 3 of 8x8, then a full restart
    delay_pix  = -1;
    cur_w      = 8;
    exp_incdec = 1'b0;
    exp_base   = 32'd5000;
    for (int i = 0; i < 4; i++) push_pix(0, i, 8, 32'd5000, 1'b0, 1);
    hs_base = hs_count;
    nr_base = nr_cnt;
    done0   = done_cnt;
    pulse_start(32'd5000, 8, 8, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge tb_clk);
      if (mem_req === 1'b1 && row_cnt == CNT_W'(0) && col_cnt == CNT_W'(3)) found = 1'b1;
    end
    check("abort_target_reached", 64'(found), 64'd1);
    check("abort_with_ack", 64'(mem_ack), 64'd1);
    abort = 1'b1;
    @(posedge tb_clk);
    #1;
    abort = 1'b0;
    @(negedge tb_clk);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_row_held", 64'(row_cnt), 64'd0);
    check("abort_col_held", 64'(col_cnt), 64'd3);
    repeat (3) @(negedge tb_clk);
    check("abort_no_done", 64'(done_cnt - done0), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    run_frame(32'd5000, 8, 8, 1'b0, -1, 0);

    repeat (5) @(negedge tb_clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
